frame_tick_bank: RTL
====================

// Module: frame_tick_bank
// PURPOSE
//  N-channel programmable tick generator; parametrised successor of the single fixed-divider frame tick.
//  Each channel divides clk by a runtime-programmable period and emits a 1-cycle enable pulse.
//  Supports periodic and one-shot modes, glitch-free period changes, and per-channel run/stop.
//  Sits between clk and the draw/game-logic blocks (frame rate, sprite animation, input debounce).
// PARAMETERS
//  N_CH        4         number of independent tick channels (1..16)
//  CNT_W       20        counter/period width in bits
//  DEF_PERIOD  833_333   period loaded into every channel at reset (tick spacing = DEF_PERIOD+1 clks)
//  CH_W        $clog2(N_CH) (min 1)  width of channel select
// PORTS
//  clk          in   1         system clock, all logic on posedge
//  reset        in   1         synchronous, active-high reset
//  cfg_we       in   1         config write strobe, 1 cycle
//  cfg_ch       in   CH_W      channel addressed by the write
//  cfg_period   in   CNT_W     new period P (tick spacing P+1 clks)
//  cfg_oneshot  in   1         mode for addressed channel: 0 periodic, 1 one-shot
//  run          in   N_CH      per-channel level: 1 = count, 0 = stop and clear
//  tick         out  N_CH      registered 1-cycle enable pulse per channel
//  done         out  N_CH      one-shot channel has fired; cleared when run drops
//  tick_any     out  1         registered OR of tick (same cycle as tick)
// BEHAVIOUR
//  Reset (sync, reset=1 at posedge): cnt=0, P_act=P_pend=DEF_PERIOD, pend=0, mode=periodic,
//   state=IDLE; tick=0, done=0, tick_any=0. Reset dominates every other input.
//  Per-channel FSM: IDLE -> RUN -> (one-shot only) DONE.
//   IDLE: cnt held 0, tick=0. run=1 sampled -> RUN, cnt<=0.
//   RUN: cnt increments; at cnt==P_act: cnt<=0, tick<=1 next cycle (registered, 1 cycle wide).
//    Periodic: stays RUN. One-shot: -> DONE, done<=1 with the tick.
//   DONE: cnt held 0, no further ticks, done=1 until run=0.
//   Any state: run=0 sampled -> IDLE, cnt<=0, done<=0; a tick already registered still completes.
//  Latency: first tick is high P_act+1 cycles after the cycle the FSM enters RUN;
//   subsequent ticks exactly P_act+1 cycles apart. P_act=0 -> tick high every cycle in RUN.
//  Terminal compare is == on CNT_W bits; cnt never exceeds P_act, so no overflow/wrap path exists.
//  Config writes: cfg_we=1 -> addressed channel gets P_pend<=cfg_period, mode<=cfg_oneshot, pend<=1.
//   cfg_ch >= N_CH: write ignored.
//   Pending period is applied only at a period boundary: on terminal count, or immediately if IDLE/DONE.
//   Write in the same cycle as terminal count: bypass -- cfg_period becomes P_act for the next period.
//   Mode change takes effect immediately; switching to one-shot mid-period fires once at the next terminal.
//   Never shortens or truncates an in-progress period (no runt ticks).
//  Simultaneous run=0 and write: both take effect; channel goes IDLE holding new P_act.
//  Channels fully independent; no cross-channel phase relationship except common start cycle.
// STRUCTURE
//  Package frame_tick_pkg: CNT_W default, DEF_PERIOD, state enum {IDLE, RUN, DONE}, mode enum
//   {MODE_PERIODIC, MODE_ONESHOT}.
//  Sub-module tick_channel (one counter, FSM, P_act/P_pend/pend, mode reg), instantiated N_CH
//   times by generate; top does cfg_ch decode, range check, tick_any OR register.
// TESTING
//  1 reset, run[0]=1, DEF_PERIOD overridden to 3 -> tick[0] high 1 cycle every 4 clks, first 4 clks after RUN entry.
//  2 ch1 P=9 running; write P=4 mid-period (cnt=5) -> next tick still 10 clks after previous,
//    then 5-clk spacing; no short interval.
//  3 ch2 one-shot P=2, run=1 -> single tick after 3 clks, done=1 persistent; run 0->1 -> fires again once.
//  4 P=0 periodic -> tick constant 1 in RUN; run=0 -> tick 0 within 1 cycle after last registered tick.
//  5 write with cfg_ch=N_CH (out of range) -> no channel's period/mode changes; write coinciding
//    with terminal count -> new period used for the immediately following interval.
//  6 reset asserted mid-count on all channels -> all outputs 0 next cycle, P_act=DEF_PERIOD, state IDLE.

Source files
------------

// File: rtl/frame_tick_pkg.sv
// frame_tick_pkg: shared types and defaults for the frame tick bank
package frame_tick_pkg;
    localparam int CNT_W_DEF = 20;
    localparam int DEF_PERIOD_DEF = 833_333;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic {MODE_PERIODIC, MODE_ONESHOT} mode_t;
    function automatic int ch_w(int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/frame_tick_bank_if.sv
// frame_tick_bank_if: config/run inputs and tick/done outputs of the tick bank
interface frame_tick_bank_if import frame_tick_pkg::*; #(
    parameter int N_CH = 4,
    parameter int CNT_W = CNT_W_DEF
);
    localparam int CH_W = ch_w(N_CH);
    logic cfg_we;
    logic [CH_W-1:0] cfg_ch;
    logic [CNT_W-1:0] cfg_period;
    logic cfg_oneshot;
    logic [N_CH-1:0] run;
    logic [N_CH-1:0] tick;
    logic [N_CH-1:0] done;
    logic tick_any;
    modport master(output cfg_we, cfg_ch, cfg_period, cfg_oneshot, run, input tick, done, tick_any);
    modport slave(input cfg_we, cfg_ch, cfg_period, cfg_oneshot, run, output tick, done, tick_any);
endinterface

// File: rtl/tick_channel.sv
// tick_channel: one programmable divider with run/stop, one-shot mode and
// period reloads deferred to the next period boundary
module tick_channel import frame_tick_pkg::*; #(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DEF_PERIOD = DEF_PERIOD_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [CNT_W-1:0] period,
    input  logic             oneshot,
    input  logic             run,
    output logic             tick,
    output logic             done,
    output logic             tick_nxt
);
    state_t state, state_nxt;
    mode_t mode, mode_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, p_act, p_act_nxt, p_pend, p_pend_nxt;
    logic pend, pend_nxt, done_nxt, bound, fire_once;
    always_comb begin
        mode_nxt = we ? mode_t'(oneshot) : mode;
        tick_nxt = run && state == RUN && cnt == p_act;
        fire_once = tick_nxt && mode_nxt == MODE_ONESHOT;
        // a write landing on the terminal cycle bypasses the pending register
        bound = !run || state != RUN || tick_nxt;
        p_pend_nxt = we ? period : p_pend;
        pend_nxt = (we || pend) && !bound;
        p_act_nxt = bound && (we || pend) ? p_pend_nxt : p_act;
        state_nxt = !run ? IDLE : state == IDLE ? RUN : fire_once ? DONE : state;
        cnt_nxt = run && state == RUN && !tick_nxt ? cnt + CNT_W'(1) : '0;
        done_nxt = run && (done || fire_once);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            mode <= MODE_PERIODIC;
            cnt <= '0;
            p_act <= CNT_W'(DEF_PERIOD);
            p_pend <= CNT_W'(DEF_PERIOD);
            pend <= 1'b0;
            tick <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= state_nxt;
            mode <= mode_nxt;
            cnt <= cnt_nxt;
            p_act <= p_act_nxt;
            p_pend <= p_pend_nxt;
            pend <= pend_nxt;
            tick <= tick_nxt;
            done <= done_nxt;
        end
    end
endmodule

// File: rtl/frame_tick_bank.sv
// frame_tick_bank: N independent programmable tick channels with a shared
// config write port and a registered any-tick flag
module frame_tick_bank import frame_tick_pkg::*; #(
    parameter int N_CH = 4,
    parameter int CNT_W = CNT_W_DEF,
    parameter int DEF_PERIOD = DEF_PERIOD_DEF
) (
    input logic clk,
    input logic reset,
    frame_tick_bank_if.slave bus
);
    localparam int CH_W = ch_w(N_CH);
    logic in_range;
    logic [N_CH-1:0] tick_v, done_v, tick_nxt;
    assign in_range = int'(bus.cfg_ch) < N_CH;
    assign bus.tick = tick_v;
    assign bus.done = done_v;
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        tick_channel #(.CNT_W(CNT_W), .DEF_PERIOD(DEF_PERIOD)) u_ch (
            .clk(clk),
            .reset(reset),
            .we(bus.cfg_we && in_range && bus.cfg_ch == CH_W'(c)),
            .period(bus.cfg_period),
            .oneshot(bus.cfg_oneshot),
            .run(bus.run[c]),
            .tick(tick_v[c]),
            .done(done_v[c]),
            .tick_nxt(tick_nxt[c])
        );
    end
    // built from next-state ticks so it rises in the same cycle as tick
    always_ff @(posedge clk) begin
        if (reset) bus.tick_any <= 1'b0;
        else bus.tick_any <= |tick_nxt;
    end
endmodule
